// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the binary-cell RAM access controller.
package ram_ctrl_pkg;

  localparam int unsigned DefaultAddrW = 2;
  localparam int unsigned DefaultDataW = 4;

  // Polarity of the RAM rd_wr pin.
  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StResp
  } ctrl_state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Valid/ready front-end sequencing the asynchronous RAM pins through setup, access and hold
// phases; read data is registered and returned on a response channel.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefaultAddrW,
  parameter int unsigned DATA_W        = DefaultDataW,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  ctrl_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              mem_en_q, mem_en_d;
  logic              rd_wr_q, rd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign req_ready = (state_q == StIdle) && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_wr_d     = rd_wr_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // Pins are loaded on the accept edge so they are settled throughout SETUP.
          state_d = StSetup;
          wr_d    = req_wr;
          addr_d  = req_addr;
          rd_wr_d = req_wr ? RAM_WR : RAM_RD;
          if (req_wr) begin
            wr_data_d = req_wdata;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = 4'(ACCESS_CYCLES - 1);
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          if (!wr_q) begin
            rsp_rdata_d = rd_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = wr_q ? StIdle : StResp;
        rd_wr_d = RAM_RD;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered outputs follow the state being entered.
    mem_en_d    = (state_d == StAccess);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      rd_wr_q     <= RAM_RD;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      rd_wr_q     <= rd_wr_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign rd_wr     = rd_wr_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: two controllers (ACCESS_CYCLES 1 and 3), each driving a behavioural 4x4 RAM.
module tb_ram_access_ctrl;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_wr, rsp_valid, rsp_ready, mem_en, rd_wr;
  logic [1:0][1:0] req_addr, addr;
  logic [1:0][3:0] req_wdata, rsp_rdata, wr_data, rd_data;

  logic [3:0] mem [2][4];
  int         en_cnt [2];
  int         addr_viol [2];
  logic [1:0] prev_en;
  logic [1:0][1:0] prev_addr;
  int         acc0, hs0;
  int         n_checks, n_pass;

  ram_access_ctrl #(.ADDR_W(2), .DATA_W(4), .ACCESS_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_en(mem_en[0]), .rd_wr(rd_wr[0]), .addr(addr[0]), .wr_data(wr_data[0]),
    .rd_data(rd_data[0])
  );

  ram_access_ctrl #(.ADDR_W(2), .DATA_W(4), .ACCESS_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_en(mem_en[1]), .rd_wr(rd_wr[1]), .addr(addr[1]), .wr_data(wr_data[1]),
    .rd_data(rd_data[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural binary-cell RAM: writes while enabled in write mode, reads combinationally.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_en[u] && !rd_wr[u]) mem[u][addr[u]] <= wr_data[u];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int u = 0; u < 2; u++) begin
      if (mem_en[u] && rd_wr[u]) rd_data[u] = mem[u][addr[u]];
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      en_cnt[u]    = 0;
      addr_viol[u] = 0;
    end
    prev_en   = '0;
    prev_addr = '0;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_en[u]) en_cnt[u]++;
      if (mem_en[u] && prev_en[u] && addr[u] != prev_addr[u]) addr_viol[u]++;
      prev_en[u]   = mem_en[u];
      prev_addr[u] = addr[u];
    end
  end

  initial begin
    acc0 = 0;
    hs0  = 0;
  end

  always @(posedge clk) begin
    if (req_valid[0] && req_ready[0]) acc0++;
    if (rsp_valid[0] && rsp_ready[0]) hs0++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns cycles from the accept edge until rsp_valid (read)
  // or req_ready (write) is seen, plus the mem_en high cycles that accumulated.
  task automatic issue(input int u, input logic wr, input logic [1:0] a, input logic [3:0] d,
                       output int lat, output int en);
    int n;
    int en0;
    req_valid[u] = 1'b1;
    req_wr[u]    = wr;
    req_addr[u]  = a;
    req_wdata[u] = d;
    n = 0;
    while (!req_ready[u] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("req_ready_timeout", req_ready[u], 1);
    en0 = en_cnt[u];
    tick();
    req_valid[u] = 1'b0;
    req_wdata[u] = ~d;
    req_addr[u]  = ~a;
    lat = 1;
    if (wr) begin
      while (!req_ready[u] && lat < 50) begin
        tick();
        lat++;
      end
    end else begin
      while (!rsp_valid[u] && lat < 50) begin
        tick();
        lat++;
      end
    end
    lat = lat - 1;
    en  = en_cnt[u] - en0;
  endtask

  task automatic wr_do(input int u, input logic [1:0] a, input logic [3:0] d, input int ac);
    int lat, en;
    issue(u, 1'b1, a, d, lat, en);
    check("wr_latency", lat, ac + 2);
    check("wr_mem_en_cycles", en, ac);
  endtask

  task automatic rd_chk(input int u, input logic [1:0] a, input logic [3:0] d, input int ac);
    int lat, en;
    issue(u, 1'b0, a, d ^ 4'h3, lat, en);
    check("rd_latency", lat, ac + 2);
    check("rd_mem_en_cycles", en, ac);
    check("rd_data", rsp_rdata[u], d);
    tick();
    check("rsp_valid_after_hs", rsp_valid[u], 0);
    check("req_ready_after_hs", req_ready[u], 1);
  endtask

  logic       seq_wr [8];
  logic [1:0] seq_a [8];
  logic [3:0] seq_d [8];
  logic [3:0] pat [4];

  initial begin
    int lat, en, n, acc_s, hs_s;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 2'b11;
    repeat (2) tick();

    for (int u = 0; u < 2; u++) begin
      check("rst_mem_en", mem_en[u], 0);
      check("rst_rd_wr", rd_wr[u], 1);
      check("rst_addr", addr[u], 0);
      check("rst_wr_data", wr_data[u], 0);
      check("rst_rsp_valid", rsp_valid[u], 0);
      check("rst_rsp_rdata", rsp_rdata[u], 0);
      check("rst_req_ready", req_ready[u], 0);
    end
    rst = 1'b0;
    #1;
    check("req_ready_after_rst", req_ready[0], 1);

    // Single write/read round trip.
    wr_do(0, 2'd2, 4'hA, 1);
    rd_chk(0, 2'd2, 4'hA, 1);

    // Walking-one pattern across all words.
    pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4; pat[3] = 4'h8;
    for (int i = 0; i < 4; i++) wr_do(0, 2'(i), pat[i], 1);
    for (int i = 0; i < 4; i++) rd_chk(0, 2'(i), pat[i], 1);

    // Response backpressure.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 2'd1, 4'h0, lat, en);
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid[0], 1);
      check("bp_rsp_rdata", rsp_rdata[0], 4'h2);
      check("bp_req_ready", req_ready[0], 0);
    end
    rsp_ready[0] = 1'b1;
    tick();
    check("bp_rsp_valid_drop", rsp_valid[0], 0);
    check("bp_req_ready_back", req_ready[0], 1);

    // Longer access window.
    wr_do(1, 2'd1, 4'h5, 3);
    rd_chk(1, 2'd1, 4'h5, 3);

    // Reset while a read is in SETUP.
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 2'd3;
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_setup_mem_en", mem_en[0], 0);
    check("rst_setup_rsp_valid", rsp_valid[0], 0);
    check("rst_setup_req_ready", req_ready[0], 0);
    rst = 1'b0;
    #1;
    check("rst_setup_ready_back", req_ready[0], 1);

    // Reset while a response is pending.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 2'd3, 4'h0, lat, en);
    check("rst_resp_pending", rsp_valid[0], 1);
    rst = 1'b1;
    tick();
    check("rst_resp_rsp_valid", rsp_valid[0], 0);
    check("rst_resp_rsp_rdata", rsp_rdata[0], 0);
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    #1;
    check("rst_resp_ready_back", req_ready[0], 1);
    rd_chk(0, 2'd3, 4'h8, 1);

    // Back-to-back requests with req_valid never dropped.
    pat[0] = 4'h3; pat[1] = 4'h6; pat[2] = 4'h9; pat[3] = 4'hC;
    for (int i = 0; i < 8; i++) begin
      seq_wr[i] = (i % 2 == 0);
      seq_a[i]  = 2'(i / 2);
      seq_d[i]  = pat[i / 2];
    end
    acc_s = acc0;
    hs_s  = hs0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_wr[0]    = seq_wr[i];
      req_addr[0]  = seq_a[i];
      req_wdata[0] = seq_d[i];
      n = 0;
      while (!req_ready[0] && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) check("b2b_ready_timeout", req_ready[0], 1);
      tick();
      if (i < 7) begin
        req_wr[0]    = seq_wr[i + 1];
        req_addr[0]  = seq_a[i + 1];
        req_wdata[0] = seq_d[i + 1];
      end else begin
        req_valid[0] = 1'b0;
      end
      if (!seq_wr[i]) begin
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
          tick();
          n++;
        end
        check("b2b_rd_data", rsp_rdata[0], seq_d[i]);
      end
    end
    repeat (3) tick();
    check("b2b_accepts", acc0 - acc_s, 8);
    check("b2b_responses", hs0 - hs_s, 4);

    check("addr_stable_u0", addr_viol[0], 0);
    check("addr_stable_u1", addr_viol[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Request/response front-end that feeds the 4x4 binary-cell RAM.
- Accepts single-word read/write requests on a valid/ready handshake.
- Sequences the RAM's asynchronous control pins (mem_en, rd_wr, addr, wr_data) through setup, access and hold phases so the decoder never glitches onto a wrong word.
- Registers read data and returns it on a valid/ready response channel.

Parameters:
- ADDR_W, 2, RAM address width (word count = 2**ADDR_W).
- DATA_W, 4, RAM word width.
- ACCESS_CYCLES, 1, cycles mem_en is held high per access; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_W  captured read word.
- mem_en  output  1  to RAM mem_en.
- rd_wr  output  1  to RAM rd_wr; 1 = read, 0 = write.
- addr  output  ADDR_W  to RAM addr.
- wr_data  output  DATA_W  to RAM wr_data.
- rd_data  input  DATA_W  from RAM rd_data; tri-stated by the RAM when not reading.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (on the edge where rst is high):
  - state = IDLE
  - mem_en = 0, rd_wr = 1, addr = 0, wr_data = 0
  - rsp_valid = 0, rsp_rdata = 0, wait counter = 0
- req_ready = (state == IDLE) && !rst. It is combinational and low throughout reset.
- All RAM-side outputs and rsp_* are registered; no combinational path from req_* to the RAM pins.
- States:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch req_wr/addr/wdata and go to SETUP.
  - SETUP (1 cycle): drive addr, wr_data and rd_wr = !wr_lat; mem_en = 0. Next state is ACCESS.
  - ACCESS (ACCESS_CYCLES cycles): mem_en = 1, other RAM outputs stable. The counter loads ACCESS_CYCLES-1 on entry and decrements. At count 0 go to HOLD. A read samples rd_data into rsp_rdata on the edge leaving ACCESS.
  - HOLD (1 cycle): mem_en = 0, addr/wr_data/rd_wr held. Next state is RESP for a read, IDLE for a write.
  - RESP: rsp_valid = 1 and rsp_rdata stable until rsp_valid && rsp_ready. Then rsp_valid = 0 next cycle and go to IDLE.
- Outside SETUP/ACCESS/HOLD: mem_en = 0 and rd_wr = 1. The last addr and wr_data are held; they are not cleared.
- Timing, with the accept edge as E0:
  - mem_en is high after edges E1 .. E(ACCESS_CYCLES).
  - For a read, rsp_valid goes high after edge E(ACCESS_CYCLES+2); with the default this is 3 cycles after accept.
  - For a write, req_ready returns high after edge E(ACCESS_CYCLES+2).
  - For a read, req_ready returns high on the cycle after the response handshake.
- Throughput: one outstanding request at most. There is no request acceptance in the same cycle the controller returns to IDLE; acceptance occurs only while in IDLE.
- Writes produce no response.
- rsp_ready held high while in RESP: the handshake completes in the first RESP cycle.
- rsp_ready low: rsp_valid and rsp_rdata hold indefinitely, and the controller stays in RESP.
- req_* changes while not ready are ignored; latched values are used throughout the access.
- Reset mid-operation: the next edge returns to IDLE with reset values, dropping mem_en and any pending response. A write interrupted during ACCESS may or may not have updated the RAM word; the bench must not check it.
- Width rules: addr and data pass through unmodified. Counter width is 4 bits.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, HOLD, RESP
  - constants RAM_RD = 1'b1, RAM_WR = 1'b0
  - default ADDR_W/DATA_W.
- No sub-module. The wait counter and FSM are small enough to live in a single ram_access_ctrl module.
- The bench instantiates ram_access_ctrl driving four_by_four_ram.

Test Plan:
- Write 4'hA to addr 2, then read addr 2 -> mem_en high exactly 1 cycle per access; rsp_valid 3 cycles after read accept; rsp_rdata = 4'hA.
- Write 4'h1/4'h2/4'h4/4'h8 to addr 0..3, then read all four -> responses 1, 2, 4, 8 in order. Also check that addr never changes while mem_en = 1.
- Read with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready low; then rsp_ready = 1 -> handshake, req_ready = 1 next cycle.
- ACCESS_CYCLES = 3 build, write then read addr 1 with 4'h5 -> mem_en high 3 consecutive cycles; rsp_valid 5 cycles after accept; data 4'h5.
- Assert rst in SETUP of a read and in RESP -> next cycle mem_en = 0, rsp_valid = 0, req_ready = 1 once rst drops; a subsequent read of a previously written address is correct.
- req_valid held high continuously with alternating write/read -> each request accepted only in IDLE, none lost or duplicated; count of accepts equals count of issued requests.
